conv_window_seq: RTL and testbench

Sequencer for one LeNet convolution layer. It walks a K×K window over an IMG_H×IMG_W feature map held in a synchronous-read buffer and issues one buffer read per tap. It also drives the clear/enable controls of the MAC accumulator register, and flags each finished output pixel with its coordinates. It sits between the layer controller (start/done) and the feature buffer plus MAC datapath, and throttles on the downstream `ready`.

---
 rtl/conv_window_seq.sv | 154 +++++++++++++++
 tb/tb_conv_window_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_seq.sv
// K x K window sequencer: one buffer read per tap, accumulator clear/enable 1 cycle later, pixel flag 2 cycles later.
// rd_en follows ready combinationally; the counters hold while ready=0, and the two pipeline stages never stall.
module conv_window_seq #(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int K      = 5,
  parameter int ADDR_W = 10,
  localparam int OW    = IMG_W - K + 1,
  localparam int OH    = IMG_H - K + 1,
  localparam int RW    = (OH > 1) ? $clog2(OH) : 1,
  localparam int CW    = (OW > 1) ? $clog2(OW) : 1,
  localparam int KW    = (K > 1) ? $clog2(K) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              ready,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              out_valid,
  output logic [RW-1:0]     out_row,
  output logic [CW-1:0]     out_col
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [ADDR_W-1:0] STEP_ROW = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] STEP_OY  = ADDR_W'(K);

  state_t            state;
  logic [RW-1:0]     oy;
  logic [CW-1:0]     ox;
  logic [KW-1:0]     ky, kx;
  logic [ADDR_W-1:0] base, row_ptr;
  logic              kx_end, ky_end, ox_end, oy_end;

  logic              s1_vld, s1_clr, s1_last, s1_fin;
  logic [RW-1:0]     s1_row;
  logic [CW-1:0]     s1_col;

  assign kx_end  = (kx == KW'(K - 1));
  assign ky_end  = (ky == KW'(K - 1));
  assign ox_end  = (ox == CW'(OW - 1));
  assign oy_end  = (oy == RW'(OH - 1));

  assign rd_en   = (state == RUN) && ready;
  assign busy    = (state != IDLE);
  assign acc_en  = s1_vld;
  assign acc_clr = s1_clr;

  // base = oy*IMG_W+ox and row_ptr = base+ky*IMG_W are stepped, never multiplied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      oy      <= '0;
      ox      <= '0;
      ky      <= '0;
      kx      <= '0;
      base    <= '0;
      row_ptr <= '0;
      rd_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            oy      <= '0;
            ox      <= '0;
            ky      <= '0;
            kx      <= '0;
            base    <= '0;
            row_ptr <= '0;
            rd_addr <= '0;
          end
        end
        RUN: begin
          if (ready) begin
            if (!kx_end) begin
              kx      <= kx + 1'b1;
              rd_addr <= rd_addr + 1'b1;
            end else begin
              kx <= '0;
              if (!ky_end) begin
                ky      <= ky + 1'b1;
                row_ptr <= row_ptr + STEP_ROW;
                rd_addr <= row_ptr + STEP_ROW;
              end else begin
                ky <= '0;
                if (!ox_end) begin
                  ox      <= ox + 1'b1;
                  base    <= base + 1'b1;
                  row_ptr <= base + 1'b1;
                  rd_addr <= base + 1'b1;
                end else begin
                  ox <= '0;
                  // From (oy, OW-1) to (oy+1, 0): +IMG_W-(OW-1) = +K.
                  if (!oy_end) begin
                    oy      <= oy + 1'b1;
                    base    <= base + STEP_OY;
                    row_ptr <= base + STEP_OY;
                    rd_addr <= base + STEP_OY;
                  end else begin
                    oy      <= '0;
                    base    <= '0;
                    row_ptr <= '0;
                    rd_addr <= '0;
                    state   <= DRAIN;
                  end
                end
              end
            end
          end
        end
        DRAIN: begin
          if (done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld    <= 1'b0;
      s1_clr    <= 1'b0;
      s1_last   <= 1'b0;
      s1_fin    <= 1'b0;
      s1_row    <= '0;
      s1_col    <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
    end else begin
      s1_vld    <= rd_en;
      s1_clr    <= rd_en && (ky == '0) && (kx == '0);
      s1_last   <= rd_en && kx_end && ky_end;
      s1_fin    <= ox_end && oy_end;
      s1_row    <= oy;
      s1_col    <= ox;
      out_valid <= s1_last;
      done      <= s1_last && s1_fin;
      if (s1_last) begin
        out_row <= s1_row;
        out_col <= s1_col;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_seq.sv
// Scoreboard bench: a 4x4/K=3 instance (throttling, restart, abort) and a 3x3/K=3 boundary instance.
module tb_conv_window_seq;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n_a = 1'b0, start_a = 1'b0, ready_a = 1'b0;
  logic       busy_a, done_a, rd_en_a, acc_clr_a, acc_en_a, out_valid_a;
  logic [9:0] rd_addr_a;
  logic [0:0] out_row_a, out_col_a;

  logic       rst_n_b = 1'b0, start_b = 1'b0, ready_b = 1'b0;
  logic       busy_b, done_b, rd_en_b, acc_clr_b, acc_en_b, out_valid_b;
  logic [9:0] rd_addr_b;
  logic [0:0] out_row_b, out_col_b;

  conv_window_seq #(.IMG_W(4), .IMG_H(4), .K(3), .ADDR_W(10)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .start(start_a), .ready(ready_a),
    .busy(busy_a), .done(done_a), .rd_en(rd_en_a), .rd_addr(rd_addr_a),
    .acc_clr(acc_clr_a), .acc_en(acc_en_a), .out_valid(out_valid_a),
    .out_row(out_row_a), .out_col(out_col_a)
  );

  conv_window_seq #(.IMG_W(3), .IMG_H(3), .K(3), .ADDR_W(10)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .start(start_b), .ready(ready_b),
    .busy(busy_b), .done(done_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b),
    .acc_clr(acc_clr_b), .acc_en(acc_en_b), .out_valid(out_valid_b),
    .out_row(out_row_b), .out_col(out_col_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  int q_addr[$];
  bit q_clr[$];
  int q_row[$];
  int q_col[$];
  bit q_fin[$];
  int q_addr_b[$];

  int n_rd_a = 0, n_ov_a = 0, n_busy_a = 0, n_done_a = 0;
  int n_rd_b = 0, n_ov_b = 0, n_done_b = 0;
  bit prev_rd_a = 1'b0;

  always @(negedge clk) begin
    if (rst_n_a) begin
      chk("acc_en_lag", int'(acc_en_a), int'(prev_rd_a));
      if (busy_a) n_busy_a++;
      if (!ready_a) chk("rd_en_stall", int'(rd_en_a), 0);
      if (rd_en_a) begin
        n_rd_a++;
        if (q_addr.size() == 0) chk("rd_extra", 1, 0);
        else chk("rd_addr", int'(rd_addr_a), q_addr.pop_front());
      end
      if (acc_en_a) begin
        if (q_clr.size() == 0) chk("acc_extra", 1, 0);
        else chk("acc_clr", int'(acc_clr_a), int'(q_clr.pop_front()));
      end else if (acc_clr_a) begin
        chk("acc_clr_alone", 1, 0);
      end
      if (out_valid_a) begin
        n_ov_a++;
        if (q_row.size() == 0) chk("ov_extra", 1, 0);
        else begin
          chk("out_row", int'(out_row_a), q_row.pop_front());
          chk("out_col", int'(out_col_a), q_col.pop_front());
          chk("done_at_ov", int'(done_a), int'(q_fin.pop_front()));
        end
      end else if (done_a) begin
        chk("done_alone", 1, 0);
      end
      if (done_a) n_done_a++;
    end
    prev_rd_a = rd_en_a;
  end

  always @(negedge clk) begin
    if (rst_n_b) begin
      if (rd_en_b) begin
        n_rd_b++;
        if (q_addr_b.size() == 0) chk("b_rd_extra", 1, 0);
        else chk("b_rd_addr", int'(rd_addr_b), q_addr_b.pop_front());
      end
      if (out_valid_b) begin
        n_ov_b++;
        chk("b_out_row", int'(out_row_b), 0);
        chk("b_out_col", int'(out_col_b), 0);
        chk("b_done", int'(done_b), 1);
      end
      if (done_b) n_done_b++;
    end
  end

  task automatic push_pass_a();
    for (int oy = 0; oy < 2; oy++)
      for (int ox = 0; ox < 2; ox++) begin
        for (int ky = 0; ky < 3; ky++)
          for (int kx = 0; kx < 3; kx++) begin
            q_addr.push_back((oy + ky) * 4 + ox + kx);
            q_clr.push_back(ky == 0 && kx == 0);
          end
        q_row.push_back(oy);
        q_col.push_back(ox);
        q_fin.push_back(oy == 1 && ox == 1);
      end
  endtask

  task automatic flush_a();
    q_addr.delete(); q_clr.delete(); q_row.delete(); q_col.delete(); q_fin.delete();
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, "_busy"},      int'(busy_a), 0);
    chk({tag, "_done"},      int'(done_a), 0);
    chk({tag, "_rd_en"},     int'(rd_en_a), 0);
    chk({tag, "_rd_addr"},   int'(rd_addr_a), 0);
    chk({tag, "_acc_clr"},   int'(acc_clr_a), 0);
    chk({tag, "_acc_en"},    int'(acc_en_a), 0);
    chk({tag, "_out_valid"}, int'(out_valid_a), 0);
    chk({tag, "_out_row"},   int'(out_row_a), 0);
    chk({tag, "_out_col"},   int'(out_col_a), 0);
  endtask

  // One full pass on dut_a; returns at negedge+1 of the done cycle (or after the budget).
  task automatic run_a(input bit throttle, input bit poke);
    int cyc;
    push_pass_a();
    n_busy_a = 0; n_rd_a = 0; n_ov_a = 0;
    @(posedge clk); #1 start_a = 1'b1; ready_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    for (cyc = 0; cyc < 600; cyc++) begin
      ready_a = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke) start_a = (cyc == 10 || cyc == 37);
      @(negedge clk); #1;
      if (done_a) break;
      @(posedge clk); #1;
    end
    if (cyc == 600) chk("done_timeout", 0, 1);
    chk("n_rd", n_rd_a, 36);
    chk("n_out_valid", n_ov_a, 4);
    chk("addr_left", q_addr.size(), 0);
    if (!throttle) chk("busy_cycles", n_busy_a, 38);
    if (poke) begin
      @(posedge clk); #1 start_a = 1'b0;
      chk("start_at_done_ignored", int'(busy_a), 0);
    end
  endtask

  initial begin
    int cyc;
    int done_before;
    #2;
    chk_zero_a("reset");
    chk("reset_b_busy", int'(busy_b), 0);
    @(posedge clk); #1 rst_n_a = 1'b1; rst_n_b = 1'b1;

    run_a(1'b0, 1'b0);
    run_a(1'b0, 1'b1);
    run_a(1'b1, 1'b0);
    run_a(1'b1, 1'b0);

    // Abort after the 20th read.
    push_pass_a();
    n_rd_a = 0;
    @(posedge clk); #1 start_a = 1'b1; ready_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    cyc = 0;
    while (n_rd_a < 20 && cyc < 200) begin
      @(negedge clk); #1;
      cyc++;
    end
    chk("abort_reads_reached", n_rd_a, 20);
    @(posedge clk); #2 rst_n_a = 1'b0;
    flush_a();
    #1 chk_zero_a("abort");
    done_before = n_done_a;
    @(posedge clk); #1 rst_n_a = 1'b1;
    repeat (4) @(negedge clk);
    #1 chk("abort_no_done", n_done_a, done_before);
    chk("abort_idle", int'(busy_a), 0);
    run_a(1'b0, 1'b0);

    // 3x3 map with K=3: a single output pixel.
    for (int i = 0; i < 9; i++) q_addr_b.push_back(i);
    @(posedge clk); #1 start_b = 1'b1; ready_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    for (cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk); #1;
      if (done_b) break;
    end
    if (cyc == 100) chk("b_done_timeout", 0, 1);
    chk("b_n_rd", n_rd_b, 9);
    chk("b_n_out_valid", n_ov_b, 1);
    chk("b_n_done", n_done_b, 1);
    @(posedge clk); #1 chk("b_idle_after", int'(busy_b), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
